// File: rtl/plic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : plic_pkg                                                  |
// | Brief    : Shared types and defaults for the PLIC interrupt gateway. |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package plic_pkg;

    // Per-source request lifecycle: waiting, offered to the core, being serviced.
    typedef enum logic [1:0] {
        GW_IDLE    = 2'd0,
        GW_PENDING = 2'd1,
        GW_CLAIMED = 2'd2
    } gw_state_e;

    // Default width of the per-source queued-edge counter.
    localparam int c_DEFAULT_EDGE_CNT_W = 3;

endpackage : plic_pkg
`default_nettype wire

// File: rtl/plic_gateway_src.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : plic_gateway_src                                          |
// | Brief    : One interrupt source: synchronizer, edge detector,        |
// |            saturating edge queue and claim/complete state machine.   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module plic_gateway_src
    import plic_pkg::*;
#(
    parameter int EDGE_CNT_W = c_DEFAULT_EDGE_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic irq_in,
    input  logic trig_edge,
    input  logic claim_hit,
    input  logic complete_hit,
    output logic pending,
    output logic in_service
);

    localparam logic [EDGE_CNT_W-1:0] c_CNT_MAX = '1;

    logic                  r_s1;
    logic                  r_s2;
    logic                  r_s2_d;
    logic                  w_edge;
    logic                  w_forward;
    logic [EDGE_CNT_W-1:0] r_cnt;
    logic [EDGE_CNT_W-1:0] w_cnt_next;
    logic [EDGE_CNT_W:0]   w_cnt_sum;
    gw_state_e             r_state;
    gw_state_e             w_state_next;

    // Two-flop synchronizer plus one history flop for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_s2_d <= 1'b0;
        end else begin
            r_s1   <= irq_in;
            r_s2   <= r_s1;
            r_s2_d <= r_s2;
        end
    end

    assign w_edge = r_s2 & ~r_s2_d;

    // A new request is only offered while nothing is in flight for this source.
    assign w_forward = (r_state == GW_IDLE) &&
                       (trig_edge ? ((r_cnt != '0) || w_edge) : r_s2);

    // Queue bookkeeping: add the incoming edge, remove the forwarded one, clamp at max.
    always_comb begin
        w_cnt_sum = {1'b0, r_cnt}
                  + {{EDGE_CNT_W{1'b0}}, w_edge}
                  - {{EDGE_CNT_W{1'b0}}, w_forward};
        if (!trig_edge) begin
            w_cnt_next = '0;
        end else if (w_cnt_sum > {1'b0, c_CNT_MAX}) begin
            w_cnt_next = c_CNT_MAX;
        end else begin
            w_cnt_next = w_cnt_sum[EDGE_CNT_W-1:0];
        end
    end

    // Edge queue register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= GW_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; claims/completes in the wrong state fall through unchanged.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            GW_IDLE:    if (w_forward)    w_state_next = GW_PENDING;
            GW_PENDING: if (claim_hit)    w_state_next = GW_CLAIMED;
            GW_CLAIMED: if (complete_hit) w_state_next = GW_IDLE;
            default:                      w_state_next = GW_IDLE;
        endcase
    end

    // Outputs are pure decodes of the state register.
    always_comb begin
        pending    = (r_state == GW_PENDING);
        in_service = (r_state == GW_CLAIMED);
    end

endmodule : plic_gateway_src
`default_nettype wire

// File: rtl/plic_gateway.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : plic_gateway                                              |
// | Brief    : Interrupt gateway array in front of the PLIC core.        |
// |            Decodes claim/complete IDs and hosts one gateway per      |
// |            source; source 0 is reserved and never pends.             |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module plic_gateway
    import plic_pkg::*;
#(
    parameter int NUM_SOURCES = 32,
    parameter int ID_WIDTH    = $clog2(NUM_SOURCES),
    parameter int EDGE_CNT_W  = c_DEFAULT_EDGE_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_SOURCES-1:0] irq_sources,
    input  logic [NUM_SOURCES-1:0] trig_edge,
    input  logic                   claim_valid,
    input  logic [ID_WIDTH-1:0]    claim_id,
    input  logic                   complete_valid,
    input  logic [ID_WIDTH-1:0]    complete_id,
    output logic [NUM_SOURCES-1:0] pending,
    output logic [NUM_SOURCES-1:0] in_service
);

    // Source 0 has no gateway; its inputs are intentionally ignored.
    logic w_unused_src0;
    assign w_unused_src0 = irq_sources[0] ^ trig_edge[0];

    assign pending[0]    = 1'b0;
    assign in_service[0] = 1'b0;

    // One gateway per real source. IDs 0 and >= NUM_SOURCES never decode to a hit.
    for (genvar i = 1; i < NUM_SOURCES; i++) begin : g_src
        logic w_claim_hit;
        logic w_complete_hit;

        assign w_claim_hit    = claim_valid    && (claim_id    == ID_WIDTH'(i));
        assign w_complete_hit = complete_valid && (complete_id == ID_WIDTH'(i));

        plic_gateway_src #(
            .EDGE_CNT_W (EDGE_CNT_W)
        ) u_src (
            .clk          (clk),
            .rst          (rst),
            .irq_in       (irq_sources[i]),
            .trig_edge    (trig_edge[i]),
            .claim_hit    (w_claim_hit),
            .complete_hit (w_complete_hit),
            .pending      (pending[i]),
            .in_service   (in_service[i])
        );
    end

endmodule : plic_gateway
`default_nettype wire
